// File: rtl/seq_gen_pkg.sv
// Shared types and default sizes for the serial pattern generator.
// Pattern width, length-field width and divider width are set here.
package seq_gen_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = $clog2(PAT_W_DEF);
    localparam int DIV_W_DEF = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/seq_gen_bit_timer.sv
// Bit-period prescaler: pc counts 0..div while enabled, and tick marks the last clock of a bit.
// clr forces pc back to 0 so that an aborted transmission leaves no partial count behind.
module seq_gen_bit_timer
    import seq_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pc_q;
    logic [DIV_W-1:0] pc_d;

    assign tick = en && (pc_q == div);

    always_comb begin
        pc_d = pc_q;
        if (clr || tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: loads a pattern word via valid/ready and shifts bits [len:0] out MSB-first.
// Each bit is held for div+1 clocks; the pattern can loop continuously while repeat_en is high.
//
//   state   | meaning
//   S_IDLE  | waiting for a load; load_ready high, serial outputs low
//   S_SHIFT | transmitting; idx selects the bit currently on ser_out
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W),
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [LEN_W-1:0] load_len,
    input  logic [DIV_W-1:0] load_div,
    input  logic             repeat_en,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic [LEN_W-1:0] idx_m1;

    assign load_ready = (state_q == S_IDLE);
    assign idx_m1     = idx_q - LEN_W'(1);

    seq_gen_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_SHIFT),
        .clr  (abort),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        div_d       = div_q;
        idx_d       = idx_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A load beats a coincident abort here: abort only acts on a running pass.
                if (load_valid) begin
                    state_d     = S_SHIFT;
                    pat_d       = load_pattern;
                    len_d       = load_len;
                    div_d       = load_div;
                    idx_d       = load_len;
                    ser_out_d   = load_pattern[load_len];
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (tick) begin
                    if (idx_q == '0) begin
                        if (repeat_en) begin
                            idx_d     = len_q;
                            ser_out_d = pat_q[len_q];
                        end else begin
                            state_d     = S_IDLE;
                            ser_out_d   = 1'b0;
                            ser_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end
                    end else begin
                        idx_d     = idx_m1;
                        ser_out_d = pat_q[idx_m1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            div_q       <= '0;
            idx_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: reset, basic shift, divider, repeat, abort, back-to-back loads.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seq_pattern_gen;

    localparam int PAT_W = 8;
    localparam int LEN_W = 3;
    localparam int DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] load_pattern;
    logic [LEN_W-1:0] load_len;
    logic [DIV_W-1:0] load_div;
    logic             repeat_en;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    seq_pattern_gen #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_pattern (load_pattern),
        .load_len     (load_len),
        .load_div     (load_div),
        .repeat_en    (repeat_en),
        .abort        (abort),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle-state output check: ser_out, ser_valid, busy, done, load_ready.
    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_ser_out"}, ser_out, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_ready"}, load_ready, 1);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic [DIV_W-1:0] d);
        load_valid   = 1'b1;
        load_pattern = p;
        load_len     = l;
        load_div     = d;
        step();
        load_valid   = 1'b0;
        load_pattern = '0;
    endtask

    initial begin
        logic [PAT_W-1:0] pat;
        logic [8:0]       rep_stream;
        int               done_cnt;

        rst          = 1'b1;
        load_valid   = 1'b0;
        load_pattern = '0;
        load_len     = '0;
        load_div     = '0;
        repeat_en    = 1'b0;
        abort        = 1'b0;

        // Reset values
        step();
        step();
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        step();
        chk_idle("post_reset", 1'b0);

        // Basic: bits [3:0] of 8'hBB are 1011, div=0 -> one clk per bit
        load(8'hBB, 3'd3, 8'd0);
        chk("basic_ready_low", load_ready, 0);
        chk("basic_busy", busy, 1);
        pat = 8'hBB;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_bit%0d", k), ser_out, pat[3-k]);
            chk($sformatf("basic_valid%0d", k), ser_valid, 1);
            chk($sformatf("basic_nodone%0d", k), done, 0);
            step();
        end
        chk_idle("basic_end", 1'b1);
        step();
        chk("basic_done_pulse", done, 0);

        // Divider: 8'hC3, len=7, div=2 -> each bit 3 clks; a load while busy is ignored
        load(8'hC3, 3'd7, 8'd2);
        pat = 8'hC3;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) begin
                load_valid   = 1'b1;
                load_pattern = 8'h3C;
                load_len     = 3'd1;
                load_div     = 8'd0;
            end
            if (k == 7) load_valid = 1'b0;
            chk($sformatf("div_bit_c%0d", k), ser_out, pat[7-(k/3)]);
            chk($sformatf("div_busy_c%0d", k), busy, 1);
            chk($sformatf("div_nodone_c%0d", k), done, 0);
            step();
        end
        load_pattern = '0;
        chk_idle("div_end", 1'b1);

        // Repeat: 3'b110 looped, repeat dropped during the 7th bit -> 9 bits then done
        step();
        repeat_en  = 1'b1;
        load(8'b0000_0110, 3'd2, 8'd0);
        rep_stream = 9'b110_110_110;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rep_bit%0d", k), ser_out, rep_stream[8-k]);
            chk($sformatf("rep_valid%0d", k), ser_valid, 1);
            chk($sformatf("rep_nodone%0d", k), done, 0);
            if (k == 6) repeat_en = 1'b0;
            step();
        end
        chk_idle("rep_end", 1'b1);

        // Abort: 8'hFF len=7 div=1, abort during T+4 -> idle at T+5, done never pulses
        step();
        load(8'hFF, 3'd7, 8'd1);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("abort_bit_t%0d", k), ser_out, 1);
            step();
        end
        chk("abort_bit_t4", ser_out, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort_t5", 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_still_idle", busy, 0);

        // Back-to-back: load_valid held; second load taken on the done cycle, with abort ignored in IDLE
        load_valid   = 1'b1;
        load_pattern = 8'h01;
        load_len     = 3'd0;
        load_div     = 8'd0;
        step();
        chk("b2b_first_bit", ser_out, 1);
        chk("b2b_first_valid", ser_valid, 1);
        load_pattern = 8'h01;
        load_len     = 3'd1;
        step();
        chk_idle("b2b_gap", 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        load_valid = 1'b0;
        chk("b2b_second_bit0", ser_out, 0);
        chk("b2b_second_valid0", ser_valid, 1);
        chk("b2b_load_beats_abort", busy, 1);
        step();
        chk("b2b_second_bit1", ser_out, 1);
        chk("b2b_second_valid1", ser_valid, 1);
        step();
        chk_idle("b2b_end", 1'b1);

        // Asynchronous reset mid-shift clears outputs before the next edge
        step();
        load(8'hA5, 3'd7, 8'd3);
        step();
        step();
        chk("rst_pre_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("rst_async", 1'b0);
        #2;
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done || busy || ser_valid) done_cnt++;
        end
        chk("rst_stays_idle", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
